// File: rtl/pill_feeder_pkg.sv
// Shared state encodings and parameter defaults for the pill feeder.
// Imported by the feeder top level.
package pill_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_INDEX = 3'd2,
        ST_STALL = 3'd3,
        ST_EMPTY = 3'd4
    } feeder_state_t;

    localparam int LEVEL_W          = 10;
    localparam int DEF_PILL_PERIOD  = 100;
    localparam int DEF_INDEX_CYCLES = 500;
    localparam int DEF_HOPPER_CAP   = 999;
    localparam int DEF_ADD_QTY      = 100;
    localparam int DEF_JAM_CYCLES   = 3000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pill_feeder_timer.sv
// Loadable, freezable up-counter with terminal-value compare; shared by the
// pill interval and the conveyor index dwell.
module feed_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         hold,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         at_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (!hold) begin
            count <= count + W'(1);
        end
    end

    assign at_last = (count == last);

endmodule

// File: rtl/pill_feeder.sv
// Pill feeder controller: paced pill dispensing, conveyor index dwell, stall,
// hopper level tracking. Optional jam detection with FEEDER_JAM_DETECT_EN.
module pill_feeder
    import pill_feeder_pkg::*;
#(
    parameter int PILL_PERIOD  = DEF_PILL_PERIOD,
    parameter int INDEX_CYCLES = DEF_INDEX_CYCLES,
    parameter int HOPPER_CAP   = DEF_HOPPER_CAP,
    parameter int ADD_QTY      = DEF_ADD_QTY,
    parameter int JAM_CYCLES   = DEF_JAM_CYCLES
) (
    input  logic               clk_1khz,
    input  logic               switch_clr,
    input  logic               run,
    input  logic               bottle_full,
    input  logic               hopper_add,
    input  logic               hopper_stop,
    input  logic               conveyor_stop,
    output logic               pill_pulse,
    output logic [LEVEL_W-1:0] hopper_level,
    output logic [2:0]         fsm_state,
    output logic               empty_alarm,
    output logic               jam
);

    localparam int CNT_W = $clog2(max_int(PILL_PERIOD, INDEX_CYCLES) + 1);
    localparam int LW1   = LEVEL_W + 1;

    localparam logic [CNT_W-1:0]   PILL_LAST  = CNT_W'(PILL_PERIOD - 1);
    localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(INDEX_CYCLES - 1);
    localparam logic [LEVEL_W:0]   CAP_X      = LW1'(HOPPER_CAP);
    localparam logic [LEVEL_W:0]   ADD_X      = LW1'(ADD_QTY);

    feeder_state_t state, next_state, saved_state;

    logic             stop;
    logic             jam_block;
    logic             tmr_load;
    logic             tmr_hold;
    logic [CNT_W-1:0] tmr_last;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_at_last;
    logic [LEVEL_W:0] level_sum;
    logic [LEVEL_W-1:0] level_next;

    function automatic logic [LEVEL_W-1:0] sat_level(input logic [LEVEL_W:0] v);
        return (v > CAP_X) ? CAP_X[LEVEL_W-1:0] : v[LEVEL_W-1:0];
    endfunction

    assign stop     = hopper_stop | conveyor_stop;
    assign tmr_last = (state == ST_INDEX) ? DWELL_LAST : PILL_LAST;

    feed_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk_1khz),
        .rst_n    (switch_clr),
        .load     (tmr_load),
        .load_val ('0),
        .hold     (tmr_hold),
        .last     (tmr_last),
        .count    (tmr_count),
        .at_last  (tmr_at_last)
    );

    // A pill only drops on an undisturbed FEED cycle with stock in the hopper.
    assign pill_pulse = run && (state == ST_FEED) && !stop && !bottle_full
                        && tmr_at_last && (hopper_level != '0);

    assign level_sum  = {1'b0, hopper_level} - LW1'(pill_pulse)
                        + (hopper_add ? ADD_X : '0);
    assign level_next = sat_level(level_sum);

    always_comb begin
        next_state = state;
        tmr_load   = 1'b1;
        tmr_hold   = 1'b0;
        if (!run) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    next_state = (hopper_level != '0) ? ST_FEED : ST_EMPTY;
                end
                ST_FEED: begin
                    if (stop) begin
                        next_state = ST_STALL;
                        tmr_load   = 1'b0;
                        tmr_hold   = 1'b1;
                    end else if (bottle_full) begin
                        next_state = ST_INDEX;
                    end else if (level_next == '0) begin
                        next_state = ST_EMPTY;
                    end else if (!tmr_at_last) begin
                        tmr_load = 1'b0;
                    end
                end
                ST_INDEX: begin
                    if (stop) begin
                        next_state = ST_STALL;
                        tmr_load   = 1'b0;
                        tmr_hold   = 1'b1;
                    end else if (tmr_at_last) begin
                        next_state = (hopper_level == '0) ? ST_EMPTY : ST_FEED;
                    end else begin
                        tmr_load = 1'b0;
                    end
                end
                ST_STALL: begin
                    tmr_load = 1'b0;
                    tmr_hold = 1'b1;
                    if (!stop && !jam_block) begin
                        next_state = saved_state;
                    end
                end
                ST_EMPTY: begin
                    if (hopper_level != '0) begin
                        next_state = ST_FEED;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            state        <= ST_IDLE;
            saved_state  <= ST_FEED;
            hopper_level <= LEVEL_W'(HOPPER_CAP);
        end else begin
            state        <= next_state;
            hopper_level <= level_next;
            // Remember where to resume once the stall clears.
            if (state != ST_STALL && next_state == ST_STALL) begin
                saved_state <= state;
            end
        end
    end

    assign fsm_state   = state;
    assign empty_alarm = (state == ST_EMPTY);

`ifdef FEEDER_JAM_DETECT_EN
    localparam int JAM_W = $clog2(JAM_CYCLES + 1);
    localparam logic [JAM_W-1:0] JAM_LAST = JAM_W'(JAM_CYCLES - 1);

    logic [JAM_W-1:0] jam_cnt;
    logic             jam_flag;

    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            jam_cnt  <= '0;
            jam_flag <= 1'b0;
        end else if (!run) begin
            jam_cnt  <= '0;
            jam_flag <= 1'b0;
        end else if (state == ST_STALL && conveyor_stop) begin
            if (jam_cnt != JAM_LAST) begin
                jam_cnt <= jam_cnt + JAM_W'(1);
            end else begin
                jam_flag <= 1'b1;
            end
        end else begin
            jam_cnt <= '0;
        end
    end

    assign jam       = jam_flag;
    assign jam_block = jam_flag;
`else
    logic unused_jam_cfg;
    assign unused_jam_cfg = (JAM_CYCLES == 0);
    assign jam            = 1'b0;
    assign jam_block      = 1'b0;
`endif

endmodule

// File: tb/tb_pill_feeder.sv
// Scoreboard bench for pill_feeder: default-timed instance plus a fast-pill
// instance used to drain the hopper within a short run.
module tb_pill_feeder;
    import pill_feeder_pkg::*;

    logic       clk = 1'b0;
    logic       switch_clr, run, bottle_full, hopper_add, hopper_stop, conveyor_stop;
    logic       pill_pulse, empty_alarm, jam;
    logic [9:0] hopper_level;
    logic [2:0] fsm_state;

    logic       f_run, f_add, zero_in;
    logic       f_pill, f_alarm, f_jam;
    logic [9:0] f_level;
    logic [2:0] f_state;

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int f_pulses = 0;
    int exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pill_feeder dut (
        .clk_1khz      (clk),
        .switch_clr    (switch_clr),
        .run           (run),
        .bottle_full   (bottle_full),
        .hopper_add    (hopper_add),
        .hopper_stop   (hopper_stop),
        .conveyor_stop (conveyor_stop),
        .pill_pulse    (pill_pulse),
        .hopper_level  (hopper_level),
        .fsm_state     (fsm_state),
        .empty_alarm   (empty_alarm),
        .jam           (jam)
    );

    pill_feeder #(.PILL_PERIOD(2), .INDEX_CYCLES(4)) dut_f (
        .clk_1khz      (clk),
        .switch_clr    (switch_clr),
        .run           (f_run),
        .bottle_full   (zero_in),
        .hopper_add    (f_add),
        .hopper_stop   (zero_in),
        .conveyor_stop (zero_in),
        .pill_pulse    (f_pill),
        .hopper_level  (f_level),
        .fsm_state     (f_state),
        .empty_alarm   (f_alarm),
        .jam           (f_jam)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every main-instance pill must match the oldest scheduled pill cycle.
    always @(negedge clk) begin
        if (switch_clr && pill_pulse) begin
            if (exp_q.size() == 0) check_val("spurious_pill", cyc, -1);
            else check_val("pill_time", cyc, exp_q.pop_front());
        end
        if (f_pill) f_pulses <= f_pulses + 1;
    end

    initial begin
        int t, base;
        switch_clr = 1'b0; run = 1'b0; bottle_full = 1'b0; hopper_add = 1'b0;
        hopper_stop = 1'b0; conveyor_stop = 1'b0;
        f_run = 1'b0; f_add = 1'b0; zero_in = 1'b0;
        tick(3);
        check_val("rst_state", fsm_state, 0);
        check_val("rst_level", hopper_level, 999);
        check_val("rst_pill", pill_pulse, 0);
        check_val("rst_alarm", empty_alarm, 0);
        check_val("rst_jam", jam, 0);
        check_val("rst_f_level", f_level, 999);
        switch_clr = 1'b1;
        tick(2);

        // Steady feeding: pills at 100, 200, 300.
        run = 1'b1; t = cyc;
        exp_q.push_back(t + 100); exp_q.push_back(t + 200); exp_q.push_back(t + 300);
        tick(350);
        check_val("feed_pending", exp_q.size(), 0);
        check_val("feed_level", hopper_level, 996);
        run = 1'b0; tick(1);
        check_val("run_low_idle", fsm_state, 0);

        // Bottle change at FEED cycle 150; bottle_full mid-INDEX is ignored.
        run = 1'b1; t = cyc;
        exp_q.push_back(t + 100); exp_q.push_back(t + 750);
        tick(150); bottle_full = 1'b1;
        tick(1);   bottle_full = 1'b0;
        check_val("index_enter", fsm_state, 2);
        tick(249); bottle_full = 1'b1;
        tick(1);   bottle_full = 1'b0;
        tick(249);
        check_val("index_last", fsm_state, 2);
        tick(1);
        check_val("index_exit", fsm_state, 1);
        tick(110);
        check_val("index_pending", exp_q.size(), 0);
        check_val("index_level", hopper_level, 994);
        run = 1'b0; tick(1);

        // Saturation on the fast instance: 49 pills to 950, then adds.
        f_run = 1'b1; t = cyc;
        tick(99);
        check_val("sat_level950", f_level, 950);
        f_add = 1'b1; tick(1); f_add = 1'b0;
        check_val("sat_add_cap", f_level, 999);
        check_val("sat_pill_now", f_pill, 1);
        f_add = 1'b1; tick(1); f_add = 1'b0;
        check_val("sat_add_pill", f_level, 999);
        f_run = 1'b0; tick(1);

        // Drain the fast instance to EMPTY, then refill.
        f_run = 1'b1; t = cyc; base = f_pulses;
        tick(1998);
        check_val("drain_level1", f_level, 1);
        check_val("drain_last_pill", f_pill, 1);
        tick(1);
        check_val("empty_level", f_level, 0);
        check_val("empty_state", f_state, 4);
        check_val("empty_alarm", f_alarm, 1);
        check_val("drain_count", f_pulses - base, 999);
        tick(4);
        check_val("empty_no_pill", f_pill, 0);
        check_val("empty_count", f_pulses - base, 999);
        f_add = 1'b1; tick(1); f_add = 1'b0;
        check_val("refill_level", f_level, 100);
        check_val("refill_wait", f_state, 4);
        tick(1);
        check_val("refill_feed", f_state, 1);
        check_val("refill_alarm", f_alarm, 0);
        check_val("f_jam_low", f_jam, 0);
        f_run = 1'b0; tick(1);

        // Conveyor stop at interval count 40 for 200 cycles.
        run = 1'b1; t = cyc;
        exp_q.push_back(t + 301);
        tick(41); conveyor_stop = 1'b1;
        tick(1);
        check_val("stall_enter", fsm_state, 3);
        tick(199);
        check_val("stall_hold", fsm_state, 3);
        conveyor_stop = 1'b0;
        tick(1);
        check_val("stall_resume", fsm_state, 1);
        tick(68);
        check_val("stall_pending", exp_q.size(), 0);
        check_val("stall_level", hopper_level, 993);

        conveyor_stop = 1'b1;
        tick(3005);
`ifdef FEEDER_JAM_DETECT_EN
        check_val("jam_set", jam, 1);
        conveyor_stop = 1'b0;
        tick(5);
        check_val("jam_blocks", fsm_state, 3);
        check_val("jam_held", jam, 1);
        run = 1'b0; tick(1);
        check_val("jam_clr_state", fsm_state, 0);
        check_val("jam_clr", jam, 0);
`else
        check_val("jam_off", jam, 0);
        check_val("long_stall", fsm_state, 3);
        conveyor_stop = 1'b0;
        tick(1);
        check_val("long_resume", fsm_state, 1);
        run = 1'b0; tick(1);
        check_val("long_idle", fsm_state, 0);
`endif

        // Reset in the middle of INDEX.
        run = 1'b1; t = cyc;
        exp_q.push_back(t + 100);
        tick(150); bottle_full = 1'b1;
        tick(1);   bottle_full = 1'b0;
        check_val("rst_index_in", fsm_state, 2);
        tick(100);
        switch_clr = 1'b0; #1;
        check_val("midrst_state", fsm_state, 0);
        check_val("midrst_level", hopper_level, 999);
        check_val("midrst_pill", pill_pulse, 0);
        tick(2);
        switch_clr = 1'b1; t = cyc;
        check_val("rel_pill", pill_pulse, 0);
        exp_q.push_back(t + 100);
        tick(1);
        check_val("rel_feed", fsm_state, 1);
        check_val("rel_pill2", pill_pulse, 0);
        tick(105);
        check_val("rel_pending", exp_q.size(), 0);
        check_val("rel_level", hopper_level, 998);
        run = 1'b0; tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
